// File: rtl/spec_log_writer.sv
// spec_log_writer
//   Consumes per-block speculation events from the repeat detector. It packs
//   them into 16-bit CFLog words and drives a single-port log memory write port.
//   A non-repeat block produces one ID word. A run of repeats produces one
//   count word, which is rewritten in place as the run grows.
//   When the log is full, events that need a new word are dropped and counted.
//   A flush pulse from software rewinds the log.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   spec_valid, spec_id             block-complete strobe and block ID
//   first_repeat, subseq_repeat     raw repeat flags, qualified by spec_valid
//   flush                           software has drained the log
//   log_wr_en/addr/data             registered log memory write (one cycle)
//   log_ptr, log_full               words allocated, log_ptr == LOG_WORDS
//   drop_cnt                        events lost while full (saturating)
module spec_log_writer #(
    parameter logic [15:0] LOG_BASE  = 16'h0000,
    parameter int          LOG_WORDS = 256,
    parameter logic [14:0] CNT_MAX   = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spec_valid,
    input  logic [7:0]  spec_id,
    input  logic        first_repeat,
    input  logic        subseq_repeat,
    input  logic        flush,
    output logic        log_wr_en,
    output logic [15:0] log_wr_addr,
    output logic [15:0] log_wr_data,
    output logic [15:0] log_ptr,
    output logic        log_full,
    output logic [15:0] drop_cnt
);
    localparam logic [15:0] LW = 16'(LOG_WORDS);

    typedef enum logic {LOGGING, FULL} state_t;

    state_t      state, state_n;
    logic [15:0] cnt_addr, cnt_addr_n;
    logic [14:0] cnt_val, cnt_val_n;
    logic        run_open, run_open_n;
    logic [15:0] ptr_n, drop_n;
    logic        wr_en_n;
    logic [15:0] wr_idx, wr_data_n;

    // State as seen after a same-cycle flush has been applied
    logic [15:0] ptr_eff, drop_eff;
    logic        open_eff, full_eff;
    logic        is_new, is_first, is_sub, extend, alloc;

    assign log_full = (log_ptr == LW);

    always_comb begin
        ptr_eff  = flush ? 16'd0 : log_ptr;
        drop_eff = flush ? 16'd0 : drop_cnt;
        open_eff = flush ? 1'b0 : run_open;
        full_eff = !flush && (state == FULL);

        // first_repeat dominates if both flags are raised
        is_first = spec_valid && first_repeat;
        is_sub   = spec_valid && !first_repeat && subseq_repeat;
        is_new   = spec_valid && !first_repeat && !subseq_repeat;
        // A saturated or missing run forces a fresh count word
        extend   = is_sub && open_eff && (cnt_val < CNT_MAX);
        alloc    = is_new || is_first || (is_sub && !extend);

        ptr_n      = ptr_eff;
        drop_n     = drop_eff;
        run_open_n = open_eff;
        cnt_val_n  = cnt_val;
        cnt_addr_n = cnt_addr;
        wr_en_n    = 1'b0;
        wr_idx     = 16'd0;
        wr_data_n  = 16'd0;

        if (extend) begin
            // In-place rewrite needs no new word, so it proceeds even when full
            cnt_val_n = cnt_val + 15'd1;
            wr_en_n   = 1'b1;
            wr_idx    = cnt_addr;
            wr_data_n = {1'b1, cnt_val + 15'd1};
        end else if (alloc) begin
            if (full_eff) begin
                drop_n     = (drop_eff == 16'hFFFF) ? drop_eff : drop_eff + 16'd1;
                run_open_n = 1'b0;
            end else begin
                wr_en_n = 1'b1;
                wr_idx  = ptr_eff;
                ptr_n   = ptr_eff + 16'd1;
                if (is_new) begin
                    wr_data_n  = {8'h00, spec_id};
                    run_open_n = 1'b0;
                end else begin
                    wr_data_n  = {1'b1, 15'd1};
                    cnt_addr_n = ptr_eff;
                    cnt_val_n  = 15'd1;
                    run_open_n = 1'b1;
                end
            end
        end

        state_n = (ptr_n == LW) ? FULL : LOGGING;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOGGING;
            log_ptr     <= 16'd0;
            drop_cnt    <= 16'd0;
            cnt_addr    <= 16'd0;
            cnt_val     <= 15'd0;
            run_open    <= 1'b0;
            log_wr_en   <= 1'b0;
            log_wr_addr <= 16'd0;
            log_wr_data <= 16'd0;
        end else begin
            state     <= state_n;
            log_ptr   <= ptr_n;
            drop_cnt  <= drop_n;
            cnt_addr  <= cnt_addr_n;
            cnt_val   <= cnt_val_n;
            run_open  <= run_open_n;
            log_wr_en <= wr_en_n;
            // Address and data only change on a write
            if (wr_en_n) begin
                log_wr_addr <= LOG_BASE + (wr_idx << 1);
                log_wr_data <= wr_data_n;
            end
        end
    end
endmodule

// File: tb/tb_spec_log_writer.sv
module tb_spec_log_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rst2_n = 1'b0;
    logic        spec_valid = 1'b0, first_repeat = 1'b0, subseq_repeat = 1'b0, flush = 1'b0;
    logic [7:0]  spec_id = 8'h00;

    logic        a_en, a_full, b_en, b_full;
    logic [15:0] a_addr, a_data, a_ptr, a_drop, b_addr, b_data, b_ptr, b_drop;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Main instance: non-zero base so address arithmetic is visible
    spec_log_writer #(.LOG_BASE(16'h1000), .LOG_WORDS(256), .CNT_MAX(15'h7FFF)) dut_a (
        .clk(clk), .rst_n(rst_n), .spec_valid(spec_valid), .spec_id(spec_id),
        .first_repeat(first_repeat), .subseq_repeat(subseq_repeat), .flush(flush),
        .log_wr_en(a_en), .log_wr_addr(a_addr), .log_wr_data(a_data),
        .log_ptr(a_ptr), .log_full(a_full), .drop_cnt(a_drop));

    // Small instance for the full / drop / flush corner cases
    spec_log_writer #(.LOG_BASE(16'h0000), .LOG_WORDS(4), .CNT_MAX(15'h7FFF)) dut_b (
        .clk(clk), .rst_n(rst2_n), .spec_valid(spec_valid), .spec_id(spec_id),
        .first_repeat(first_repeat), .subseq_repeat(subseq_repeat), .flush(flush),
        .log_wr_en(b_en), .log_wr_addr(b_addr), .log_wr_data(b_data),
        .log_ptr(b_ptr), .log_full(b_full), .drop_cnt(b_drop));

    typedef struct {
        bit          sel;      // 0: dut_a, 1: dut_b
        bit          v;
        logic [7:0]  id;
        bit          fr, sr, fl;
        bit          e_en;
        logic [15:0] e_addr, e_data, e_ptr;
        bit          e_full;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit sel, bit v, logic [7:0] id, bit fr, bit sr, bit fl,
                                bit e_en, logic [15:0] e_addr, logic [15:0] e_data,
                                logic [15:0] e_ptr, bit e_full, logic [15:0] e_drop);
        vec_t r;
        r.sel = sel; r.v = v; r.id = id; r.fr = fr; r.sr = sr; r.fl = fl;
        r.e_en = e_en; r.e_addr = e_addr; r.e_data = e_data; r.e_ptr = e_ptr;
        r.e_full = e_full; r.e_drop = e_drop;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] id, input bit fr, input bit sr, input bit fl);
        @(negedge clk);
        spec_valid = v; spec_id = id; first_repeat = fr; subseq_repeat = sr; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input bit sel, input string tag, input bit e_en,
                             input logic [15:0] e_addr, input logic [15:0] e_data,
                             input logic [15:0] e_ptr, input bit e_full, input logic [15:0] e_drop);
        logic en, full;
        logic [15:0] addr, data, ptr, drop;
        en   = sel ? b_en   : a_en;
        addr = sel ? b_addr : a_addr;
        data = sel ? b_data : a_data;
        ptr  = sel ? b_ptr  : a_ptr;
        full = sel ? b_full : a_full;
        drop = sel ? b_drop : a_drop;
        chk({tag, " wr_en"}, 32'(en), 32'(e_en));
        if (e_en) begin
            chk({tag, " wr_addr"}, 32'(addr), 32'(e_addr));
            chk({tag, " wr_data"}, 32'(data), 32'(e_data));
        end
        chk({tag, " log_ptr"}, 32'(ptr), 32'(e_ptr));
        chk({tag, " log_full"}, 32'(full), 32'(e_full));
        chk({tag, " drop_cnt"}, 32'(drop), 32'(e_drop));
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(tbl[i].v, tbl[i].id, tbl[i].fr, tbl[i].sr, tbl[i].fl);
            check_out(tbl[i].sel, $sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_addr,
                      tbl[i].e_data, tbl[i].e_ptr, tbl[i].e_full, tbl[i].e_drop);
        end
    endtask

    initial begin
        int n_a;
        // ----- dut_a: ID words, flush rewind, count run -----
        //                sel v  id    fr sr fl  en addr      data      ptr  full drop
        tbl.push_back(mk(0, 1, 8'h03, 0, 0, 0,  1, 16'h1000, 16'h0003, 16'd1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  0, 16'h0000, 16'h0000, 16'd1, 0, 16'd0));
        tbl.push_back(mk(0, 1, 8'h07, 0, 0, 0,  1, 16'h1002, 16'h0007, 16'd2, 0, 16'd0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0,  0, 16'h0000, 16'h0000, 16'd2, 0, 16'd0));
        tbl.push_back(mk(0, 1, 8'h09, 0, 0, 0,  1, 16'h1004, 16'h0009, 16'd3, 0, 16'd0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1,  0, 16'h0000, 16'h0000, 16'd0, 0, 16'd0));
        tbl.push_back(mk(0, 1, 8'h05, 0, 0, 0,  1, 16'h1000, 16'h0005, 16'd1, 0, 16'd0));
        tbl.push_back(mk(0, 1, 8'h05, 1, 0, 0,  1, 16'h1002, 16'h8001, 16'd2, 0, 16'd0));
        tbl.push_back(mk(0, 1, 8'h05, 0, 1, 0,  1, 16'h1002, 16'h8002, 16'd2, 0, 16'd0));
        tbl.push_back(mk(0, 1, 8'h05, 0, 1, 0,  1, 16'h1002, 16'h8003, 16'd2, 0, 16'd0));
        tbl.push_back(mk(0, 1, 8'h05, 0, 1, 0,  1, 16'h1002, 16'h8004, 16'd2, 0, 16'd0));
        tbl.push_back(mk(0, 1, 8'h05, 0, 1, 0,  1, 16'h1002, 16'h8005, 16'd2, 0, 16'd0));
        n_a = tbl.size();
        // ----- dut_b (LOG_WORDS=4): fill, in-place while full, drops, flush+event -----
        tbl.push_back(mk(1, 1, 8'h01, 0, 0, 0,  1, 16'h0000, 16'h0001, 16'd1, 0, 16'd0));
        tbl.push_back(mk(1, 1, 8'h02, 0, 0, 0,  1, 16'h0002, 16'h0002, 16'd2, 0, 16'd0));
        tbl.push_back(mk(1, 1, 8'h03, 0, 0, 0,  1, 16'h0004, 16'h0003, 16'd3, 0, 16'd0));
        tbl.push_back(mk(1, 1, 8'h03, 1, 0, 0,  1, 16'h0006, 16'h8001, 16'd4, 1, 16'd0));
        tbl.push_back(mk(1, 1, 8'h03, 0, 1, 0,  1, 16'h0006, 16'h8002, 16'd4, 1, 16'd0));
        tbl.push_back(mk(1, 1, 8'h04, 0, 0, 0,  0, 16'h0000, 16'h0000, 16'd4, 1, 16'd1));
        tbl.push_back(mk(1, 1, 8'h05, 0, 0, 0,  0, 16'h0000, 16'h0000, 16'd4, 1, 16'd2));
        // run was closed by the drop, so this SUBSEQ needs a new word and is dropped
        tbl.push_back(mk(1, 1, 8'h05, 0, 1, 0,  0, 16'h0000, 16'h0000, 16'd4, 1, 16'd3));
        tbl.push_back(mk(1, 1, 8'h2A, 0, 0, 1,  1, 16'h0000, 16'h002A, 16'd1, 0, 16'd0));
        tbl.push_back(mk(1, 1, 8'h2B, 0, 0, 0,  1, 16'h0002, 16'h002B, 16'd2, 0, 16'd0));

        // reset state
        #12;
        check_out(0, "reset", 1'b0, 16'h0, 16'h0, 16'd0, 1'b0, 16'd0);
        chk("reset wr_addr", 32'(a_addr), 32'h0);
        chk("reset wr_data", 32'(a_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_range(0, n_a);

        // Count run up to saturation: cnt_val is 5, 32762 more reach 0x7FFF
        for (int i = 0; i < 32762; i++) drive(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
        check_out(0, "sat", 1'b1, 16'h1002, 16'hFFFF, 16'd2, 1'b0, 16'd0);
        drive(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
        check_out(0, "sat_new", 1'b1, 16'h1004, 16'h8001, 16'd3, 1'b0, 16'd0);

        // flush with SUBSEQ on an open run: flush first, new count word at word 0
        drive(1'b1, 8'h05, 1'b0, 1'b1, 1'b1);
        check_out(0, "flush_sub", 1'b1, 16'h1000, 16'h8001, 16'd1, 1'b0, 16'd0);

        // asynchronous reset mid-run, while a write is being presented
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        check_out(0, "pre_rst", 1'b1, 16'h1002, 16'h0011, 16'd2, 1'b0, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        check_out(0, "mid_rst", 1'b0, 16'h0, 16'h0, 16'd0, 1'b0, 16'd0);
        chk("mid_rst wr_addr", 32'(a_addr), 32'h0);
        chk("mid_rst wr_data", 32'(a_data), 32'h0);
        @(negedge clk);
        spec_valid = 1'b0; subseq_repeat = 1'b0;
        rst_n = 1'b1;
        drive(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
        check_out(0, "post_rst", 1'b1, 16'h1000, 16'h8001, 16'd1, 1'b0, 16'd0);

        // small-log instance
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst2_n = 1'b1;
        run_range(n_a, tbl.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
